// File: rtl/input_conditioner.sv
// Multi-channel pin conditioner: per-channel synchronizer, qualification-time
// debounce, edge pulses, and sticky change flags rolled up into one irq.

module ic_lane #(
  parameter int SYNC_STAGES = 2,
  parameter int DB_CYCLES   = 600_000,
  parameter int CNT_WIDTH   = 20,
  parameter bit RESET_LEVEL = 1'b0
) (
  input  logic clk,
  input  logic reset,
  input  logic raw,
  input  logic clr,
  output logic clean,
  output logic rise,
  output logic fall,
  output logic changed
);
  localparam logic [CNT_WIDTH-1:0] LAST = CNT_WIDTH'(DB_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync_ff;
  logic [CNT_WIDTH-1:0]   cnt;
  logic                   sync;
  logic                   upd;

  assign sync = sync_ff[SYNC_STAGES-1];
  // Level accepted only after sync has disagreed for DB_CYCLES consecutive cycles.
  assign upd  = (sync != clean) && (cnt == LAST);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_ff <= {SYNC_STAGES{RESET_LEVEL}};
      clean   <= RESET_LEVEL;
      cnt     <= '0;
      rise    <= 1'b0;
      fall    <= 1'b0;
      changed <= 1'b0;
    end else begin
      sync_ff <= {sync_ff[SYNC_STAGES-2:0], raw};
      rise    <= upd & sync;
      fall    <= upd & ~sync;
      // Set wins over a coincident clear.
      changed <= upd | (changed & ~clr);
      if (sync == clean || upd) cnt <= '0;
      else                      cnt <= cnt + 1'b1;
      if (upd) clean <= sync;
    end
  end
endmodule

module input_conditioner #(
  parameter int NUM_IN      = 4,
  parameter int SYNC_STAGES = 2,
  parameter int DB_CYCLES   = 600_000,
  parameter int CNT_WIDTH   = 20,
  parameter int RESET_LEVEL = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [NUM_IN-1:0] in_raw,
  input  logic [NUM_IN-1:0] clr_changed,
  output logic [NUM_IN-1:0] in_clean,
  output logic [NUM_IN-1:0] in_rise,
  output logic [NUM_IN-1:0] in_fall,
  output logic [NUM_IN-1:0] changed,
  output logic              irq
);
  ic_lane #(
    .SYNC_STAGES(SYNC_STAGES),
    .DB_CYCLES  (DB_CYCLES),
    .CNT_WIDTH  (CNT_WIDTH),
    .RESET_LEVEL(RESET_LEVEL != 0)
  ) u_lane [NUM_IN-1:0] (
    .clk    (clk),
    .reset  (reset),
    .raw    (in_raw),
    .clr    (clr_changed),
    .clean  (in_clean),
    .rise   (in_rise),
    .fall   (in_fall),
    .changed(changed)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) irq <= 1'b0;
    else       irq <= |changed;
  end
endmodule
